// File: rtl/cache_req_arbiter.sv
// Two-master arbiter in front of the unified cache port: one transaction in flight,
// responses routed back to the master that owns the outstanding request.
module cache_req_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_req_value_i,
  input  logic [STRB_WIDTH-1:0] m0_req_wstrb_i,
  output logic                  m0_req_ready_o,
  output logic                  m0_resp_valid_o,
  output logic [DATA_WIDTH-1:0] m0_resp_value_o,
  input  logic                  m1_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_req_value_i,
  input  logic [STRB_WIDTH-1:0] m1_req_wstrb_i,
  output logic                  m1_req_ready_o,
  output logic                  m1_resp_valid_o,
  output logic [DATA_WIDTH-1:0] m1_resp_value_o,
  output logic                  s_req_valid_o,
  output logic [ADDR_WIDTH-1:0] s_req_addr_o,
  output logic [DATA_WIDTH-1:0] s_req_value_o,
  output logic [STRB_WIDTH-1:0] s_req_wstrb_o,
  input  logic                  s_req_ready_i,
  input  logic                  s_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] s_resp_value_i,
  output logic                  spurious_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e state_q;
  logic   owner_q;
  logic   rr_q;
  logic   grant_c;
  logic   winner_c;

  // Arbitration only while idle; ready is held low while reset is asserted.
  always_comb begin
    grant_c  = 1'b0;
    winner_c = 1'b0;
    if (rst_ni && (state_q == IDLE) && (m0_req_valid_i || m1_req_valid_i)) begin
      grant_c = 1'b1;
      if (m0_req_valid_i && m1_req_valid_i) begin
        winner_c = (FIXED_PRIO != 0) ? 1'b0 : rr_q;
      end else begin
        winner_c = m1_req_valid_i;
      end
    end
  end

  assign m0_req_ready_o = grant_c & ~winner_c;
  assign m1_req_ready_o = grant_c & winner_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      rr_q            <= 1'b0;
      s_req_valid_o   <= 1'b0;
      s_req_addr_o    <= '0;
      s_req_value_o   <= '0;
      s_req_wstrb_o   <= '0;
      m0_resp_valid_o <= 1'b0;
      m0_resp_value_o <= '0;
      m1_resp_valid_o <= 1'b0;
      m1_resp_value_o <= '0;
      spurious_o      <= 1'b0;
    end else begin
      m0_resp_valid_o <= 1'b0;
      m1_resp_valid_o <= 1'b0;
      // A response is only meaningful once the cache has taken the request.
      if (s_resp_valid_i && (state_q != WAIT)) begin
        spurious_o <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (grant_c) begin
            s_req_addr_o  <= winner_c ? m1_req_addr_i  : m0_req_addr_i;
            s_req_value_o <= winner_c ? m1_req_value_i : m0_req_value_i;
            s_req_wstrb_o <= winner_c ? m1_req_wstrb_i : m0_req_wstrb_i;
            owner_q       <= winner_c;
            s_req_valid_o <= 1'b1;
            state_q       <= REQ;
            if (FIXED_PRIO == 0) begin
              rr_q <= ~winner_c;
            end
          end
        end
        REQ: begin
          if (s_req_ready_i) begin
            s_req_valid_o <= 1'b0;
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          if (s_resp_valid_i) begin
            if (owner_q) begin
              m1_resp_valid_o <= 1'b1;
              m1_resp_value_o <= s_resp_value_i;
            end else begin
              m0_resp_valid_o <= 1'b1;
              m0_resp_value_o <= s_resp_value_i;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Two-master request arbiter directly upstream of the unified cache's single req/resp port.
- Master 0 is the instruction-fetch port; master 1 is the load/store port.
- Serialises their requests with one transaction outstanding at a time, because the cache response carries no ID.
- Routes each cache response back to the master that issued the request.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, request/response data width
STRB_WIDTH, DATA_WIDTH/8, write strobe width
FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins ties

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m0_req_valid_i  in  1  master 0 request valid
m0_req_addr_i  in  ADDR_WIDTH  master 0 address
m0_req_value_i  in  DATA_WIDTH  master 0 write data
m0_req_wstrb_i  in  STRB_WIDTH  master 0 byte strobes (0 = read)
m0_req_ready_o  out  1  master 0 request accepted (combinational)
m0_resp_valid_o  out  1  master 0 response pulse
m0_resp_value_o  out  DATA_WIDTH  master 0 response data
m1_*  same seven ports as m0_*, for master 1
s_req_valid_o  out  1  request valid to cache
s_req_addr_o  out  ADDR_WIDTH  latched address
s_req_value_o  out  DATA_WIDTH  latched write data
s_req_wstrb_o  out  STRB_WIDTH  latched strobes
s_req_ready_i  in  1  cache ready
s_resp_valid_i  in  1  cache response pulse
s_resp_value_i  in  DATA_WIDTH  cache response data
spurious_o  out  1  sticky: response seen with nothing outstanding

Behaviour:
- One clock domain (clk_i). rst_ni is asynchronous and active-low. All state is cleared on assertion; release is synchronous to clk_i.
- Reset values: all *_valid_o = 0, all *_ready_o = 0, s_req_* payload = 0, m*_resp_value_o = 0, spurious_o = 0, owner = 0, rr pointer = 0, state = IDLE.
- FSM states: IDLE, REQ, WAIT.
- IDLE arbitration:
  - If neither master is valid, stay in IDLE.
  - If exactly one master is valid, it wins.
  - If both are valid, the winner is rr_q (FIXED_PRIO=0) or master 0 (FIXED_PRIO=1).
- IDLE grant (same cycle as arbitration):
  - Winner's mX_req_ready_o = 1 combinationally; the loser's ready stays 0.
  - Latch addr/value/wstrb into the s_req_* registers and latch owner = winner.
  - Set s_req_valid_o <= 1 and go to REQ.
  - If FIXED_PRIO=0, rr_q <= ~winner.
- Master handshake: a master must hold valid and payload stable until it sees ready. The arbiter never asserts ready outside IDLE.
- REQ:
  - s_req_valid_o stays 1 with stable payload.
  - On s_req_valid_o & s_req_ready_i: s_req_valid_o <= 0, go to WAIT.
  - s_req_valid_o is high for exactly the handshake cycle(s) and never for the cycle after acceptance, so the cache does not see a duplicate request.
- WAIT:
  - On s_resp_valid_i: m[owner]_resp_valid_o <= 1 for exactly one cycle, m[owner]_resp_value_o <= s_resp_value_i, go to IDLE.
  - Response latency to the master is s_resp_valid_i + 1 cycle.
  - The other master's resp_valid_o stays 0.
  - resp_value_o holds its last value when not valid.
- Back-to-back: a new grant may occur in the same cycle as the registered response pulse to the previous owner. Minimum transaction time is 3 cycles plus cache latency.
- s_resp_valid_i in IDLE or REQ is dropped (never forwarded) and sets spurious_o = 1, which holds until reset.
- s_resp_valid_i in the same cycle as the REQ handshake is treated as spurious; the FSM still advances to WAIT.
- A master deasserting valid before ready is a protocol violation; behaviour is not required.
- Reset mid-transaction aborts it: the pending request is discarded, the owner never receives a response, and the cache must be reset together with the arbiter.
- Reads and writes are treated identically. The arbiter never inspects wstrb, address or data.

Test Plan:
- Single read: m0 valid, addr=0x0000_1040, wstrb=0; cache ready=1, resp 2 cycles after accept with 0xDEADBEEF -> m0_req_ready_o pulses in cycle 0; s_req_valid_o is high for exactly 1 cycle; m0_resp_valid_o=1 with value 0xDEADBEEF 1 cycle after s_resp_valid_i; m1 outputs stay 0.
- Contention round-robin (FIXED_PRIO=0): both masters valid continuously for 4 transactions -> grant order 0,1,0,1; each response routed to the correct master; no overlap of s_req_valid_o between transactions.
- Fixed priority (FIXED_PRIO=1): both masters valid for 3 transactions -> m0 granted 3 times; m1_req_ready_o stays 0 until m0 drops valid.
- Long miss: s_req_ready_i=0 for 5 cycles in REQ, then 1, then resp after 40 cycles with wstrb=4'b0011, value 0x1234_5678 -> payload stable throughout REQ; no new grants during WAIT even with m1 valid; response goes to the correct owner.
- Spurious response: s_resp_valid_i pulse while in IDLE -> spurious_o=1 and stays 1; no m*_resp_valid_o pulse; the next normal transaction completes correctly.
- Async reset in WAIT: assert rst_ni low mid-cycle -> all outputs 0 immediately; after release, state is IDLE, rr_q=0 and a new m1 request is granted normally.
